// File: rtl/count_capture_fifo.sv
// Extends an 8-bit event count with a wrap counter and queues capture-strobe snapshots in a FWFT FIFO.
// Optional macro COUNT_CAPTURE_DROP_COUNT_EN adds a saturating drop_count output.
module count_capture_fifo #(
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               value_in,
    input  logic                     overflow_in,
    input  logic                     capture,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WRAP_W+7:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped,
    input  logic                     drop_clr
`ifdef COUNT_CAPTURE_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = WRAP_W + 8;

    logic              ovf_q;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              dropped_q;
    logic [DW-1:0]     mem_q [DEPTH];

    logic rise, full, empty, pop, push, drop;

    // A rise in the same cycle as a capture must already show the new wrap value.
    assign rise   = overflow_in & ~ovf_q;
    assign wrap_d = wrap_q + WRAP_W'(rise);

    assign full  = (cnt_q == LW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = ~empty & out_ready;
    assign push  = capture & (~full | pop);
    assign drop  = capture & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + LW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            wrap_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            ovf_q  <= overflow_in;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            // A drop coinciding with a clear keeps the flag set so the loss is not hidden.
            if (drop) begin
                dropped_q <= 1'b1;
            end else if (drop_clr) begin
                dropped_q <= 1'b0;
            end
        end
    end

    // Storage is data-only; validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {wrap_d, value_in};
    end

`ifdef COUNT_CAPTURE_DROP_COUNT_EN
    logic [7:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (drop_clr) begin
            drop_count_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_count_q != 8'hFF) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign out_valid = ~empty;
    assign out_data  = mem_q[rptr_q];
    assign level     = cnt_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: directed vector table, hand sequences, and randomized traffic vs a queue model.
module tb_count_capture_fifo;

    localparam int DEPTH  = 4;
    localparam int WRAP_W = 8;

    logic        clk;
    logic        reset;
    logic [7:0]  value_in;
    logic        overflow_in;
    logic        capture;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  level;
    logic        dropped;
    logic        drop_clr;
`ifdef COUNT_CAPTURE_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    count_capture_fifo #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .overflow_in(overflow_in),
        .capture(capture), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .level(level), .dropped(dropped), .drop_clr(drop_clr)
`ifdef COUNT_CAPTURE_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] q[$];
    int          m_wrap = 0;
    logic        m_ovf  = 1'b0;
    logic        m_drop = 1'b0;
    int          m_dc   = 0;

    typedef struct {
        logic        r, cap;
        logic [7:0]  val;
        logic        ovf, rdy, clr;
        logic        ev;
        int          el;
        logic [15:0] ed;
        logic        edr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic cap, logic [7:0] val, logic ovf, logic rdy,
                                logic clr, logic ev, int el, logic [15:0] ed, logic edr);
        vec_t v;
        v.r = r; v.cap = cap; v.val = val; v.ovf = ovf; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.el = el; v.ed = ed; v.edr = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic cap, input logic [7:0] val,
                                input logic ovf, input logic rdy, input logic clr);
        int   nw;
        logic rise, popv, dropnow;
        logic [7:0] nw8;
        if (r) begin
            q.delete();
            m_wrap = 0; m_ovf = 1'b0; m_drop = 1'b0; m_dc = 0;
        end else begin
            rise    = ovf && !m_ovf;
            nw      = (m_wrap + (rise ? 1 : 0)) % (1 << WRAP_W);
            nw8     = nw[7:0];
            popv    = (q.size() > 0) && rdy;
            dropnow = 1'b0;
            if (popv) void'(q.pop_front());
            if (cap) begin
                if (q.size() < DEPTH) q.push_back({nw8, val});
                else dropnow = 1'b1;
            end
            if (dropnow) m_drop = 1'b1;
            else if (clr) m_drop = 1'b0;
            if (clr) m_dc = dropnow ? 1 : 0;
            else if (dropnow && m_dc < 255) m_dc++;
            m_wrap = nw;
            m_ovf  = ovf;
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_level", 32'(level), 32'(q.size()));
        if (q.size() > 0) chk("m_data", 32'(out_data), 32'(q[0]));
        chk("m_dropped", 32'(dropped), 32'(m_drop));
`ifdef COUNT_CAPTURE_DROP_COUNT_EN
        chk("m_drop_count", 32'(drop_count), 32'(m_dc));
`endif
    endtask

    task automatic step(input logic r, input logic cap, input logic [7:0] val,
                        input logic ovf, input logic rdy, input logic clr);
        reset = r; capture = cap; value_in = val; overflow_in = ovf;
        out_ready = rdy; drop_clr = clr;
        @(posedge clk);
        model_update(r, cap, val, ovf, rdy, clr);
        #1;
        check_model();
    endtask

    initial begin
        reset = 1'b1; capture = 1'b0; value_in = '0; overflow_in = 1'b0;
        out_ready = 1'b0; drop_clr = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 8'h99, 1, 1, 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_dropped", 32'(dropped), 0);

        //                r cap val   ovf rdy clr  ev lvl data      dropped
        tbl.push_back(mk(0, 1, 8'h2A, 0, 0, 0,   1, 1, 16'h002A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0,   1, 1, 16'h0100, 0));
        tbl.push_back(mk(0, 0, 8'h01, 1, 1, 0,   0, 0, 16'h0000, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 8'h02, 1, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 8'h05, 1, 0, 0,   1, 1, 16'h0105, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 0, 16'h0000, 0));
        // Fill to overflow with values 1..6
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0,   1, 1, 16'h0101, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 0, 0,   1, 2, 16'h0101, 0));
        tbl.push_back(mk(0, 1, 8'h03, 0, 0, 0,   1, 3, 16'h0101, 0));
        tbl.push_back(mk(0, 1, 8'h04, 0, 0, 0,   1, 4, 16'h0101, 0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 0, 0,   1, 4, 16'h0101, 1));
        tbl.push_back(mk(0, 1, 8'h06, 0, 0, 0,   1, 4, 16'h0101, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 3, 16'h0102, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 2, 16'h0103, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 1, 16'h0104, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 0, 16'h0000, 0));
        // Full with simultaneous push and pop
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0,   1, 1, 16'h0111, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0, 0, 0,   1, 2, 16'h0111, 0));
        tbl.push_back(mk(0, 1, 8'h13, 0, 0, 0,   1, 3, 16'h0111, 0));
        tbl.push_back(mk(0, 1, 8'h14, 0, 0, 0,   1, 4, 16'h0111, 0));
        tbl.push_back(mk(0, 1, 8'h15, 0, 1, 0,   1, 4, 16'h0112, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 3, 16'h0113, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 2, 16'h0114, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 1, 16'h0115, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 0, 16'h0000, 0));
        // Reset mid-stream
        tbl.push_back(mk(0, 1, 8'h21, 0, 0, 0,   1, 1, 16'h0121, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0,   1, 2, 16'h0121, 0));
        tbl.push_back(mk(0, 1, 8'h23, 0, 0, 0,   1, 3, 16'h0121, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0,   0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 8'h07, 0, 0, 0,   1, 1, 16'h0007, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 0, 16'h0000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].cap, tbl[i].val, tbl[i].ovf, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tv%0d_level", i), 32'(level), 32'(tbl[i].el));
            if (tbl[i].ev) chk($sformatf("tv%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tv%0d_dropped", i), 32'(dropped), 32'(tbl[i].edr));
        end

        // Wrap field modulo 2^WRAP_W
        for (int i = 0; i < 255; i++) begin
            step(0, 0, 8'h00, 1, 0, 0);
            step(0, 0, 8'h00, 0, 0, 0);
        end
        step(0, 1, 8'h44, 0, 0, 0);
        chk("wrap255_data", 32'(out_data), 32'h0000FF44);
        step(0, 0, 8'h00, 0, 1, 0);
        step(0, 1, 8'h00, 1, 0, 0);
        chk("wrap256_data", 32'(out_data), 32'h00000000);
        step(0, 0, 8'h00, 0, 1, 0);
        step(0, 0, 8'h00, 0, 0, 0);

        // Drop coinciding with drop_clr keeps the flag set
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i + 8'h50), 0, 0, 0);
        step(0, 1, 8'h60, 0, 0, 1);
        chk("drop_vs_clr", 32'(dropped), 1);
`ifdef COUNT_CAPTURE_DROP_COUNT_EN
        chk("drop_vs_clr_count", 32'(drop_count), 1);
`endif
        step(0, 0, 8'h00, 0, 0, 1);
        chk("clr_alone", 32'(dropped), 0);
        chk("stall_head", 32'(out_data), 32'h00000050);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 50),
                 8'($urandom),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
